cla_add_sub_pipe: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 8-bit two-group CLA.
- Splits a DATA_WIDTH operand into GROUP_WIDTH-bit CLA groups and processes one group per pipeline stage.
- Carry is registered between stages; operand groups are skewed on input and deskewed on output.
- Sits in the FPU add/sub datapath (mantissa add, exponent difference) with a valid/ready stream handshake on both sides.

---
 rtl/cla_add_sub_pipe_if.sv | 27 ++
 rtl/cla_add_sub_pipe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cla_add_sub_pipe_if.sv
// Stream interface for cla_add_sub_pipe: operand side (valid/ready in) and result side (valid/ready out).
interface cla_add_sub_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_valid;
    logic                  o_ready;
    logic                  i_sub;
    logic                  i_carry;
    logic [DATA_WIDTH-1:0] i_data_a;
    logic [DATA_WIDTH-1:0] i_data_b;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_sum;
    logic                  o_carry;
    logic                  o_overflow;
    logic                  o_zero;

    modport slave (
        input  i_valid, i_sub, i_carry, i_data_a, i_data_b, i_ready,
        output o_ready, o_valid, o_sum, o_carry, o_overflow, o_zero
    );

    modport master (
        output i_valid, i_sub, i_carry, i_data_a, i_data_b, i_ready,
        input  o_ready, o_valid, o_sum, o_carry, o_overflow, o_zero
    );
endinterface

// File: rtl/cla_add_sub_pipe.sv
// Pipelined CLA adder/subtractor, one GROUP_WIDTH group per stage, skewed operands and deskewed result.
// Define CLA_ADD_SUB_SAT_EN to saturate signed overflow at the output stage.
module cla_group #(
    parameter int GROUP_WIDTH = 8
) (
    input  logic [GROUP_WIDTH-1:0] a,
    input  logic [GROUP_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [GROUP_WIDTH-1:0] sum,
    output logic                   cout
);
    logic [GROUP_WIDTH-1:0] g, p;
    logic [GROUP_WIDTH:0]   carry;

    assign g = a & b;
    assign p = a ^ b;

    // Prefix generate/propagate so every carry is a direct function of cin.
    always_comb begin
        logic gacc, pacc;
        gacc     = 1'b0;
        pacc     = 1'b1;
        carry[0] = cin;
        for (int i = 0; i < GROUP_WIDTH; i++) begin
            gacc         = g[i] | (p[i] & gacc);
            pacc         = p[i] & pacc;
            carry[i + 1] = gacc | (pacc & cin);
        end
    end

    assign sum  = p ^ carry[GROUP_WIDTH-1:0];
    assign cout = carry[GROUP_WIDTH];
endmodule

module cla_add_sub_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int GROUP_WIDTH = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    cla_add_sub_pipe_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int GW = GROUP_WIDTH;
    localparam int NG = DATA_WIDTH / GROUP_WIDTH;

    if (DATA_WIDTH % GROUP_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of GROUP_WIDTH");
    end
    if (GROUP_WIDTH < 4 || (GROUP_WIDTH & (GROUP_WIDTH - 1)) != 0) begin : g_bad_group
        $error("GROUP_WIDTH must be a power of two, 4 or greater");
    end

    logic          advance;
    logic [NG:0]   vld_pipe;
    logic [W-1:0]  sum_q;
    logic          carry_q, ovf_q, zero_q;

    assign advance     = bus.i_ready | ~vld_pipe[NG];
    assign bus.o_ready = advance;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        vld_pipe <= '0;
        else if (advance) vld_pipe <= {vld_pipe[NG-1:0], bus.i_valid};
    end

    // Stage k consumes the low group of its operand slice and forwards the rest;
    // its sum register grows by one group per stage.
    for (genvar k = 0; k < NG; k++) begin : g_stage
        localparam int OW = (NG - k) * GW;
        logic [OW-1:0]       a_src, b_src;
        logic                cin_src, c_q, grp_cout;
        logic [GW-1:0]       grp_sum;
        logic [(k+1)*GW-1:0] s_nxt, s_q;

        if (k == 0) begin : g_in
            assign a_src   = bus.i_data_a;
            assign b_src   = bus.i_sub ? ~bus.i_data_b : bus.i_data_b;
            assign cin_src = bus.i_sub ^ bus.i_carry;
            assign s_nxt   = grp_sum;
        end else begin : g_chain
            assign a_src   = g_stage[k-1].g_skew.a_q;
            assign b_src   = g_stage[k-1].g_skew.b_q;
            assign cin_src = g_stage[k-1].c_q;
            assign s_nxt   = {grp_sum, g_stage[k-1].s_q};
        end

        cla_group #(.GROUP_WIDTH(GW)) u_grp (
            .a    (a_src[GW-1:0]),
            .b    (b_src[GW-1:0]),
            .cin  (cin_src),
            .sum  (grp_sum),
            .cout (grp_cout)
        );

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (advance) begin
                s_q <= s_nxt;
                c_q <= grp_cout;
            end
        end

        if (k < NG - 1) begin : g_skew
            logic [OW-GW-1:0] a_q, b_q;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_src[OW-1:GW];
                    b_q <= b_src[OW-1:GW];
                end
            end
        end else begin : g_msb
            logic a_msb, b_msb;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    a_msb <= 1'b0;
                    b_msb <= 1'b0;
                end else if (advance) begin
                    a_msb <= a_src[GW-1];
                    b_msb <= b_src[GW-1];
                end
            end
        end
    end

    logic [W-1:0] raw_sum, res_sum;
    logic         a_msb, b_msb, ovf;

    assign raw_sum = g_stage[NG-1].s_q;
    assign a_msb   = g_stage[NG-1].g_msb.a_msb;
    assign b_msb   = g_stage[NG-1].g_msb.b_msb;
    assign ovf     = (a_msb == b_msb) && (raw_sum[W-1] != a_msb);

`ifdef CLA_ADD_SUB_SAT_EN
    // Clamp toward the sign of A; both operands share that sign when overflow occurs.
    assign res_sum = !ovf  ? raw_sum :
                     a_msb ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    assign res_sum = raw_sum;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (advance) begin
            sum_q   <= res_sum;
            carry_q <= g_stage[NG-1].c_q;
            ovf_q   <= ovf;
            zero_q  <= ~|res_sum;
        end
    end

    assign bus.o_valid    = vld_pipe[NG];
    assign bus.o_sum      = sum_q;
    assign bus.o_carry    = carry_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_zero     = zero_q;
endmodule
